// File: rtl/seq_mult16.sv
`timescale 1ns/1ps
// seq_mult16: multi-cycle radix-2 shift-add multiplier feeding the multiply
// input of the ALU result-select mux. It accepts two operands on a start
// pulse, iterates one multiplier bit per clock, and presents a registered
// product together with a one-cycle done pulse. The product is held until
// the next operation completes.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request pulse; accepted only in IDLE or DONE
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   in0, in1     multiplicand / multiplier (sampled with start)
//   busy         high while an operation iterates
//   done         one-cycle pulse on the cycle prod is updated
//   prod         registered 2*WIDTH-bit product, holds the last result
module seq_mult16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 accept_s;
    logic                 last_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   shifted_s;
    logic [2*WIDTH-1:0]   result_s;

    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 neg_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic                 busy_r;
    logic                 done_r;

    // Magnitude of an operand. The most negative value maps onto itself,
    // which is its correct unsigned magnitude, so no overflow occurs.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sm);
        if (sm && v[WIDTH-1]) begin
            return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    assign last_s = (state_r == ST_RUN) && (cnt_r == CNT_W'(WIDTH - 1));

    // Next-state logic and start acceptance.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // One iteration step: conditional add into the upper half with the
    // carry kept, then shift {carry, hi, lo} right by one. On the final
    // step the shifted value is the full unsigned product.
    always_comb begin
        sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        shifted_s = {sum_s, lo_r[WIDTH-1:1]};
        if (neg_r) begin
            result_s = ~shifted_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result_s = shifted_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            neg_r   <= 1'b0;
        end else if (accept_s) begin
            mcand_r <= magnitude(in0, signed_mode);
            lo_r    <= magnitude(in1, signed_mode);
            hi_r    <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            neg_r   <= signed_mode & (in0[WIDTH-1] ^ in1[WIDTH-1]);
        end else if (state_r == ST_RUN) begin
            hi_r    <= shifted_s[2*WIDTH-1:WIDTH];
            lo_r    <= shifted_s[WIDTH-1:0];
            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r   <= cnt_r;
        end
    end

    // Registered outputs: product updates only on the completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r <= {(2*WIDTH){1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (last_s) begin
                prod_r <= result_s;
            end else begin
                prod_r <= prod_r;
            end
            busy_r <= (state_s == ST_RUN);
            done_r <= last_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign prod = prod_r;

endmodule

// File: tb/tb_seq_mult16.sv
`timescale 1ns/1ps
// Testbench for seq_mult16: directed scenarios plus randomized operations,
// checked against an arithmetic reference model.
module tb_seq_mult16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        busy;
    logic        done;
    logic [31:0] prod;

    int pass_cnt;
    int check_cnt;

    seq_mult16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .in0         (in0),
        .in1         (in1),
        .busy        (busy),
        .done        (done),
        .prod        (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic sm);
        longint sa;
        longint sb;
        if (sm) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        return 32'(sa * sb);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a negedge: present a request, let one edge take it, then
    // scramble the inputs to show they are not re-sampled.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic sm);
        in0 = a;
        in1 = b;
        signed_mode = sm;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in0 = 16'($urandom);
        in1 = 16'($urandom);
        signed_mode = 1'($urandom);
    endtask

    // Count edges after the start edge until done; optionally pulse a
    // start with other operands at RUN cycle 'inject'.
    task automatic wait_done(input string tag, input int inject, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == inject) begin
                in0 = 16'h1111;
                in1 = 16'h2222;
                start = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            check({tag, "_busy_run"}, {62'd0, busy, done}, {62'd0, 2'b10});
        end
    endtask

    // Full operation: launch, wait, and compare against the model.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input int inject);
        logic [31:0] exp;
        int lat;
        exp = model(a, b, sm);
        launch(a, b, sm);
        wait_done(tag, inject, lat);
        check({tag, "_latency"}, 64'(lat), 64'd16);
        check({tag, "_prod"}, {32'd0, prod}, {32'd0, exp});
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    endtask

    // Idle for n cycles: no done pulse, busy low, product held.
    task automatic idle_check(input string tag, input int n, input logic [31:0] exp);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) seen++;
        end
        check({tag, "_quiet"}, 64'(seen), 64'd0);
        check({tag, "_hold"}, {32'd0, prod}, {32'd0, exp});
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        pass_cnt = 0;
        check_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        in0 = 16'h0000;
        in1 = 16'h0000;

        // Reset held for three cycles, then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {31'd0, busy, done, prod}, 64'd0);
        rst_n = 1'b1;
        idle_check("reset_idle", 5, 32'h0000_0000);

        // Unsigned maximum operands: carry must be kept.
        run_op("unsigned_max", 16'hFFFF, 16'hFFFF, 1'b0, 0);
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        idle_check("unsigned_hold", 4, 32'hFFFE_0001);

        // Signed cases including the most negative value.
        run_op("signed_m3x7", 16'hFFFD, 16'h0007, 1'b1, 0);
        idle_check("signed_gap", 2, 32'hFFFF_FFEB);
        run_op("signed_minxmin", 16'h8000, 16'h8000, 1'b1, 0);
        idle_check("signed_gap2", 2, 32'h4000_0000);
        run_op("signed_minx1", 16'h8000, 16'h0001, 1'b1, 0);
        idle_check("signed_gap3", 2, 32'hFFFF_8000);

        // Zero operand still runs the full latency.
        run_op("zero_operand", 16'h0000, 16'h1234, 1'b0, 0);
        idle_check("zero_gap", 2, 32'h0000_0000);

        // Start while busy is ignored.
        run_op("start_busy", 16'h0012, 16'h0034, 1'b0, 5);
        check("start_busy_value", {32'd0, prod}, 64'h0000_03A8);
        idle_check("start_busy_no_second", 20, 32'h0000_03A8);

        // Back-to-back: second start presented in the DONE cycle.
        run_op("b2b_first", 16'h0002, 16'h0002, 1'b0, 0);
        run_op("b2b_second", 16'h0003, 16'h0005, 1'b0, 0);
        check("b2b_second_value", {32'd0, prod}, 64'h0000_000F);
        idle_check("b2b_gap", 2, 32'h0000_000F);

        // Reset in the middle of a run.
        launch(16'h1234, 16'h0010, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", {31'd0, busy, done, prod}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("midreset_no_done", 20, 32'h0000_0000);
        run_op("after_reset", 16'h0002, 16'h0003, 1'b0, 0);
        check("after_reset_value", {32'd0, prod}, 64'h0000_0006);

        // Randomized operations, some back-to-back, some with gaps.
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            run_op("random", ra, rb, rs, 0);
            if ($urandom_range(1, 0) == 1) begin
                idle_check("random_gap", 2, model(ra, rb, rs));
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
